// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, valid/ready output, frame/overrun error pulses.
// Optional even-parity checking is enabled with the UART_RX_PARITY_EN macro.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);
  localparam int CW = $clog2(OVS_FACTOR);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS_FACTOR/2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVS_FACTOR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  if (OVS_FACTOR < 4 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
    $fatal(1, "uart_rx: OVS_FACTOR must be a power of 2 and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $fatal(1, "uart_rx: DATA_BITS must be in 5..8");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t                 state, state_nxt;
  logic [1:0]             rx_sync;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   cnt_clr, sample_bit, load, ferr;

  always_ff @(posedge clk or posedge reset)
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx};
  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (tick_16x) begin
      case (state)
        IDLE:  if (!rx_s) state_nxt = START;
        START: if (cnt == CNT_MID) state_nxt = rx_s ? IDLE : DATA;
        DATA:  if (cnt == CNT_END && bit_idx == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                 state_nxt = PARITY;
        PARITY: if (cnt == CNT_END) state_nxt = STOP;
`else
                 state_nxt = STOP;
`endif
        STOP:  if (cnt == CNT_END) state_nxt = rx_s ? IDLE : BREAK;
        BREAK: if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_chk, par_bad;
`endif

  // Per-tick strobes; cnt is held at 0 outside the bit-timing states.
  always_comb begin
    cnt_clr    = 1'b0;
    sample_bit = 1'b0;
    load       = 1'b0;
    ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk    = 1'b0;
`endif
    if (tick_16x) begin
      case (state)
        IDLE:   cnt_clr = 1'b1;
        START:  if (cnt == CNT_MID) cnt_clr = 1'b1;
        DATA:   if (cnt == CNT_END) sample_bit = 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt == CNT_END) par_chk = 1'b1;
`endif
        STOP:   if (cnt == CNT_END) begin
                  load = rx_s;
                  ferr = !rx_s;
                end
        BREAK:  cnt_clr = 1'b1;
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (tick_16x) begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (cnt_clr)         bit_idx <= '0;
      else if (sample_bit) bit_idx <= bit_idx + BW'(1);
      if (sample_bit) shreg[bit_idx] <= rx_s;
    end

  // A load in the same cycle as an accept keeps rx_valid high and is not an overrun.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr;
      overrun_err <= load & rx_valid & !rx_ready;
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end

`ifdef UART_RX_PARITY_EN
  // Mismatch is remembered and reported alongside the stop-bit outcome.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_chk) par_bad <= (^shreg) ^ rx_s;
      parity_err <= (load | ferr) & par_bad;
    end
`else
  assign parity_err = 1'b0;
`endif

endmodule
